// File: rtl/lsu_arbiter_pkg.sv
// Shared types for the LSU arbiter: sequencer states, port identifier and
// the largest supported read latency.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // 0 = CPU data path, 1 = debug / program loader
  typedef logic port_id_t;

  localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/lsu_arbiter_if.sv
// One master port of the LSU arbiter: request/command in, grant/ack/read data out.
interface lsu_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, ack, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, ack, rdata);

endinterface

// File: rtl/lsu_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a tie goes to the port named by prio.
module rr_arb2
  import lsu_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   prio,
  output logic [1:0] gnt_onehot
);

  // Pick the winner; at most one bit is ever set
  always_comb begin
    gnt_onehot    = 2'b00;
    gnt_onehot[0] = req[0] & (~req[1] | ~prio);
    gnt_onehot[1] = req[1] & (~req[0] |  prio);
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares one load/store unit between the CPU (port 0) and the debug loader
// (port 1). One transaction at a time: grant in IDLE, a single strobe cycle
// in ISSUE, optional WAIT for read latency, then a registered ack.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  lsu_arbiter_if.slave  m0,
  lsu_arbiter_if.slave  m1,
  output logic          lsu_we,
  output logic          lsu_re,
  output logic [AW-1:0] lsu_addr,
  output logic [DW-1:0] lsu_wdata,
  input  logic [DW-1:0] lsu_rdata,
  output logic          busy
);

  localparam int CNT_W = $clog2(RD_LAT_MAX + 1);

  arb_state_t    state_q, state_d;
  port_id_t      prio_q, prio_d;
  port_id_t      cap_port_q, cap_port_d;
  logic          cap_we_q, cap_we_d;
  logic [AW-1:0] cap_addr_q, cap_addr_d;
  logic [DW-1:0] cap_wdata_q, cap_wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]    ack_q, ack_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic [1:0]    arb_gnt;
  logic [1:0]    gnt;
  logic          sample_rd;

  rr_arb2 u_rr_arb2 (
    .req        ({m1.req, m0.req}),
    .prio       (prio_q),
    .gnt_onehot (arb_gnt)
  );

  // Grants exist only while idle; reset suppresses every externally visible pulse
  always_comb begin
    gnt       = (state_q == IDLE && !rst) ? arb_gnt : 2'b00;
    lsu_we    = !rst && (state_q == ISSUE) &&  cap_we_q;
    lsu_re    = !rst && (state_q == ISSUE) && !cap_we_q;
    lsu_addr  = cap_addr_q;
    lsu_wdata = cap_wdata_q;
    busy      = (state_q != IDLE);
    m0.gnt    = gnt[0];
    m1.gnt    = gnt[1];
    m0.ack    = ack_q[0] & ~rst;
    m1.ack    = ack_q[1] & ~rst;
    m0.rdata  = rdata0_q;
    m1.rdata  = rdata1_q;
  end

  // Sequencer next-state: capture on grant, strobe once, count down read latency
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cap_port_d  = cap_port_q;
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cnt_d       = cnt_q;
    ack_d       = 2'b00;
    sample_rd   = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          cap_port_d  = gnt[1];
          cap_we_d    = gnt[1] ? m1.we    : m0.we;
          cap_addr_d  = gnt[1] ? m1.addr  : m0.addr;
          cap_wdata_d = gnt[1] ? m1.wdata : m0.wdata;
          // The loser of this round holds priority for the next tie
          prio_d      = ~gnt[1];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (cap_we_q) begin
          ack_d[cap_port_q] = 1'b1;
          state_d           = IDLE;
        end else if (RD_LAT == 0) begin
          sample_rd         = 1'b1;
          ack_d[cap_port_q] = 1'b1;
          state_d           = IDLE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          sample_rd         = 1'b1;
          ack_d[cap_port_q] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data lands only in the owning port's register; writes leave both alone
  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (sample_rd) begin
      if (cap_port_q) rdata1_d = lsu_rdata;
      else            rdata0_d = lsu_rdata;
    end
  end

  // State and datapath registers, all cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cap_port_q  <= 1'b0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cnt_q       <= '0;
      ack_q       <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cap_port_q  <= cap_port_d;
      cap_we_q    <= cap_we_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: three instances with read latencies 1, 0 and 3,
// a small LSU read model per instance and an ack scoreboard.
module tb_lsu_arbiter;

  typedef struct {
    int          d;
    int          p;
    int          c;
    logic [31:0] rd;
  } exp_t;

  typedef struct {
    int d;
    int p;
    int c;
  } gl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic [1:0]  req   [3];
  logic [1:0]  we    [3];
  logic [31:0] addr  [3][2];
  logic [31:0] wdata [3][2];

  wire  [1:0]  gnt   [3];
  wire  [1:0]  ack   [3];
  wire  [31:0] rdata [3][2];
  wire         lsu_we    [3];
  wire         lsu_re    [3];
  wire  [31:0] lsu_addr  [3];
  wire  [31:0] lsu_wdata [3];
  wire  [31:0] lsu_rdata [3];
  wire         busy      [3];

  int          lat_of [3] = '{1, 0, 3};
  logic [31:0] last_rd [3][2];
  logic        pwe [3];
  logic        pre [3];

  exp_t exp_q[$];
  gl_t  glog[$];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_fn(logic [31:0] a);
    return a ^ 32'h1234_5668;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    lsu_arbiter_if #(.AW(32), .DW(32)) m0_if ();
    lsu_arbiter_if #(.AW(32), .DW(32)) m1_if ();

    assign m0_if.req   = req[g][0];
    assign m0_if.we    = we[g][0];
    assign m0_if.addr  = addr[g][0];
    assign m0_if.wdata = wdata[g][0];
    assign m1_if.req   = req[g][1];
    assign m1_if.we    = we[g][1];
    assign m1_if.addr  = addr[g][1];
    assign m1_if.wdata = wdata[g][1];
    assign gnt[g]      = {m1_if.gnt, m0_if.gnt};
    assign ack[g]      = {m1_if.ack, m0_if.ack};
    assign rdata[g][0] = m0_if.rdata;
    assign rdata[g][1] = m1_if.rdata;

    lsu_arbiter #(.RD_LAT(LAT), .AW(32), .DW(32)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0_if),
      .m1        (m1_if),
      .lsu_we    (lsu_we[g]),
      .lsu_re    (lsu_re[g]),
      .lsu_addr  (lsu_addr[g]),
      .lsu_wdata (lsu_wdata[g]),
      .lsu_rdata (lsu_rdata[g]),
      .busy      (busy[g])
    );

    // LSU model: data valid only LAT cycles after the read strobe, junk otherwise
    int          re_cyc = -100;
    logic [31:0] re_addr = '0;
    always @(posedge clk) if (lsu_re[g]) begin
      re_cyc  <= cyc;
      re_addr <= lsu_addr[g];
    end
    if (LAT == 0) begin : g_l0
      assign lsu_rdata[g] = lsu_re[g] ? rd_fn(lsu_addr[g]) : (32'hBAD0_0000 ^ cyc);
    end else begin : g_ln
      assign lsu_rdata[g] = (cyc == re_cyc + LAT) ? rd_fn(re_addr) : (32'hBAD0_0000 ^ cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Ack scoreboard and per-cycle strobe/grant sanity
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (ack[d][p]) begin
          if (exp_q.size() == 0) chk("unexpected_ack", {d[31:0], p[31:0]}, 64'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("ack_dut", d, e.d);
            chk("ack_port", p, e.p);
            chk("ack_cycle", cyc, e.c);
            chk("ack_rdata", rdata[d][p], e.rd);
          end
        end
      end
      chk("strobe_rules", {lsu_we[d] & lsu_re[d], lsu_we[d] & pwe[d], lsu_re[d] & pre[d], gnt[d][0] & gnt[d][1]}, 0);
      pwe[d] <= lsu_we[d];
      pre[d] <= lsu_re[d];
    end
  end

  // Caller is just after a rising edge; returns just after the edge two cycles past grant
  task automatic do_txn(input int d, input int p, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output int gc);
    int   n;
    exp_t e;
    n = 0;
    req[d][p] = 1'b1; we[d][p] = w; addr[d][p] = a; wdata[d][p] = wd;
    @(negedge clk);
    while (!gnt[d][p] && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!gnt[d][p]) chk("gnt_timeout", 0, 1);
    gc = cyc;
    glog.push_back('{d: d, p: p, c: gc});
    e.d = d; e.p = p;
    e.c = gc + 2 + (w ? 0 : lat_of[d]);
    if (w) e.rd = last_rd[d][p];
    else begin
      e.rd = rd_fn(a);
      last_rd[d][p] = rd_fn(a);
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) req[d][p] = 1'b0;
    @(negedge clk);
    chk("issue_we", lsu_we[d], w);
    chk("issue_re", lsu_re[d], !w);
    chk("issue_addr", lsu_addr[d], a);
    if (w) chk("issue_wdata", lsu_wdata[d], wd);
    chk("issue_busy", busy[d], 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input int n, input int gap, input bit alt);
    chk("log_len", glog.size(), n);
    if (glog.size() > 0) chk("log_first", glog[0].p, 0);
    for (int i = 1; i < glog.size(); i++) begin
      chk("log_port", glog[i].p, alt ? (glog[i-1].p ^ 1) : glog[i-1].p);
      chk("log_gap", glog[i].c - glog[i-1].c, gap);
    end
  endtask

  task automatic run_pair(input int d, input bit w, input int n);
    glog.delete();
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int gc0;
          do_txn(d, 0, w, 32'h100 + 4 * i, 32'hA000_0000 + i, i < n - 1, gc0);
        end
      end
      begin
        for (int j = 0; j < n; j++) begin
          int gc1;
          do_txn(d, 1, w, 32'h200 + 4 * j, 32'hB000_0000 + j, j < n - 1, gc1);
        end
      end
    join
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    int gc;
    for (int d = 0; d < 3; d++) begin
      req[d] = 2'b00; we[d] = 2'b00;
      pwe[d] = 1'b0; pre[d] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        addr[d][p] = '0; wdata[d][p] = '0; last_rd[d][p] = '0;
      end
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", busy[d], 0);
      chk("rst_strobes", {lsu_we[d], lsu_re[d], gnt[d], ack[d]}, 0);
      chk("rst_lsu_addr", lsu_addr[d], 0);
      chk("rst_lsu_wdata", lsu_wdata[d], 0);
      chk("rst_rdata", {rdata[d][1], rdata[d][0]}, 0);
    end
    @(posedge clk); #1;

    // Single write then single read
    do_txn(0, 0, 1, 32'h0000_7000, 32'hDEAD_BEEF, 0, gc);
    drain();
    do_txn(0, 1, 0, 32'h0000_0010, 32'h0, 0, gc);
    drain();
    chk("m1_read_value", rdata[0][1], 32'h1234_5678);
    chk("m0_after_write", rdata[0][0], 32'h0);

    // Contention: alternating grants
    run_pair(0, 1, 2);
    chk_log(4, 2, 1);
    drain();
    run_pair(0, 0, 2);
    chk_log(4, 3, 1);
    drain();

    // Lone continuous requester
    glog.delete();
    for (int i = 0; i < 3; i++) do_txn(0, 0, 1, 32'h300 + 4 * i, 32'hC000_0000 + i, i < 2, gc);
    chk_log(3, 2, 0);
    drain();

    // Reset during WAIT of a port-0 read
    do_txn(0, 0, 0, 32'h40, 32'h0, 0, gc);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rstw_re", lsu_re[0], 0);
    chk("rstw_ack", ack[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) for (int p = 0; p < 2; p++) last_rd[d][p] = '0;
    @(negedge clk);
    chk("rstw_busy", busy[0], 0);
    chk("rstw_lsu_addr", lsu_addr[0], 0);
    chk("rstw_lsu_wdata", lsu_wdata[0], 0);
    chk("rstw_rdata", {rdata[0][1], rdata[0][0]}, 0);
    chk("rstw_ack2", ack[0], 0);
    @(posedge clk); #1;
    run_pair(0, 1, 1);
    chk_log(2, 2, 1);
    drain();

    // Other read latencies
    do_txn(1, 1, 0, 32'h10, 32'h0, 0, gc);
    drain();
    do_txn(1, 0, 1, 32'h20, 32'h5555_AAAA, 0, gc);
    drain();
    do_txn(2, 1, 0, 32'h10, 32'h0, 0, gc);
    drain();
    do_txn(2, 0, 0, 32'h8000_0004, 32'h0, 0, gc);
    drain();
    chk("lat3_m1_rdata", rdata[2][1], 32'h1234_5678);

    chk("pending_acks", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
